// File: rtl/uart_rx.sv
// UART receiver: 16x (or 8x) oversampled deframer with a valid/ready output
// and parity, framing and overrun status for the word on rx_data.
`timescale 1ns/1ps
module uart_rx #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx_en,
  input  logic       rx,
  input  logic [2:0] data_bits,
  input  logic [1:0] parity,
  input  logic       stop_bit,
  input  logic       rx_ready,
  output logic [8:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun_err,
  output logic       rx_idle
);

  localparam logic [3:0] CNT_HALF = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic       rx_s;
  logic [3:0] cnt, cnt_nxt, bit_cnt;
  logic [8:0] shreg;
  logic [2:0] db_l;
  logic [1:0] par_l;
  logic       stop_l, stop_cnt, par_pend, frame_pend, brk_wait, done;
  logic       par_en, sample_mid, start_det, data_smp, par_smp, stop_smp, last_stop;

  function automatic logic [3:0] bits_last(input logic [2:0] db);
    case (db)
      3'd0:    return 4'd4;
      3'd1:    return 4'd5;
      3'd2:    return 4'd6;
      3'd3:    return 4'd7;
      3'd4:    return 4'd8;
      default: return 4'd7;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  assign par_en     = ^par_l;
  assign sample_mid = baud_tick && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // done blocks re-arming so the finished word is not clobbered before it loads
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (baud_tick && rx_en && !rx_s && !brk_wait && !done) state_nxt = START;
      START:   if (baud_tick && cnt == CNT_HALF) state_nxt = rx_s ? IDLE : DATA;
      DATA:    if (sample_mid && bit_cnt == bits_last(db_l)) state_nxt = par_en ? PARITY : STOP;
      PARITY:  if (sample_mid) state_nxt = STOP;
      STOP:    if (sample_mid && stop_cnt == stop_l) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start_det = (state == IDLE) && (state_nxt == START);
    data_smp  = (state == DATA) && sample_mid;
    par_smp   = (state == PARITY) && sample_mid;
    stop_smp  = (state == STOP) && sample_mid;
    last_stop = stop_smp && (stop_cnt == stop_l);
    cnt_nxt   = cnt;
    if (baud_tick) begin
      if (state == IDLE || state_nxt != state || cnt == CNT_LAST) cnt_nxt = 4'd0;
      else                                                        cnt_nxt = cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0; bit_cnt <= 4'd0; shreg <= 9'd0; db_l <= 3'd0; par_l <= 2'd0;
      stop_l <= 1'b0; stop_cnt <= 1'b0; par_pend <= 1'b0; frame_pend <= 1'b0;
      brk_wait <= 1'b0; done <= 1'b0;
    end else begin
      cnt  <= cnt_nxt;
      done <= last_stop;
      if (start_det) begin
        db_l <= data_bits; par_l <= parity; stop_l <= stop_bit;
        shreg <= 9'd0; bit_cnt <= 4'd0; stop_cnt <= 1'b0;
        par_pend <= 1'b0; frame_pend <= 1'b0;
      end
      if (data_smp) begin
        shreg[bit_cnt] <= rx_s;
        bit_cnt        <= bit_cnt + 4'd1;
      end
      if (par_smp) par_pend <= (^shreg) ^ rx_s ^ (par_l == 2'b01);
      if (stop_smp) begin
        frame_pend <= frame_pend | ~rx_s;
        stop_cnt   <= stop_cnt + 1'b1;
      end
      // a low final stop sample means a break: wait for the line to return high
      if (last_stop && !rx_s)          brk_wait <= 1'b1;
      else if (state == IDLE && rx_s)  brk_wait <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data <= 9'd0; rx_valid <= 1'b0; parity_err <= 1'b0;
      frame_err <= 1'b0; overrun_err <= 1'b0; rx_idle <= 1'b1;
    end else begin
      rx_idle <= (state_nxt == IDLE);
      if (done) begin
        rx_data     <= shreg;
        parity_err  <= par_pend;
        frame_err   <= frame_pend;
        rx_valid    <= 1'b1;
        overrun_err <= rx_valid & ~rx_ready;
      end else if (rx_valid && rx_ready) begin
        rx_valid    <= 1'b0;
        parity_err  <= 1'b0;
        frame_err   <= 1'b0;
        overrun_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected words, a
// monitor pops and compares on every valid & ready handshake.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int BIT = 64;  // 16 ticks x 4 clks per tick

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
    logic       oe;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst, rx_en, rx, stop_bit, rx_ready;
  logic [2:0] data_bits;
  logic [1:0] parity;
  logic [1:0] tdiv = 2'd0;
  logic       baud_tick;
  logic [8:0] rx_data;
  logic       rx_valid, parity_err, frame_err, overrun_err, rx_idle;
  logic       abort_tx = 1'b0;
  int         checks = 0;
  int         errors = 0;
  exp_t       exp_q[$];
  exp_t       mon_e;

  uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_en(rx_en), .rx(rx),
    .data_bits(data_bits), .parity(parity), .stop_bit(stop_bit), .rx_ready(rx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
    .frame_err(frame_err), .overrun_err(overrun_err), .rx_idle(rx_idle)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tdiv <= tdiv + 2'd1;
  assign baud_tick = (tdiv == 2'd3);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word: got data 0x%0h, expected no word", rx_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rx_word{data,pe,fe,oe}", 32'({rx_data, parity_err, frame_err, overrun_err}), 32'(mon_e));
      end
    end
  end

  task automatic push(input logic [8:0] d, input logic pe, input logic fe, input logic oe);
    exp_q.push_back({d, pe, fe, oe});
  endtask

  task automatic send_bits(input logic [15:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      rx = abort_tx ? 1'b1 : b[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  // par: 0 none, 1 odd, 2 even; flip inverts the correct parity bit
  task automatic send_frame(input logic [8:0] d, input int nb, input int par, input bit flip,
                            input int nstop, input logic stop_v);
    logic [15:0] bits;
    logic p;
    int k;
    bits = '1;
    bits[0] = 1'b0;
    k = 1;
    p = 1'b0;
    for (int i = 0; i < nb; i++) begin
      bits[k] = d[i];
      p ^= d[i];
      k++;
    end
    if (par != 0) begin
      bits[k] = ((par == 1) ? ~p : p) ^ flip;
      k++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[k] = stop_v;
      k++;
    end
    send_bits(bits, k);
  endtask

  task automatic wait_idle(input logic v, input int limit, input string name);
    int n = 0;
    while (rx_idle !== v && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, 32'(rx_idle), 32'(v));
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx = 1'b1; rx_en = 1'b1; rx_ready = 1'b1;
    data_bits = 3'b011; parity = 2'b00; stop_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_values", 32'({rx_data, rx_valid, parity_err, frame_err, overrun_err, rx_idle}), 32'h001);
    rst = 1'b0;
    send_bits(16'hFFFF, 2);

    // 8N1 0xA5 with latency and accept check
    push(9'h0A5, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(9'h0A5, 8, 0, 1'b0, 1, 1'b1);
      begin
        int n = 0;
        while (!rx_valid && n < 1000) begin
          @(posedge clk);
          #1;
          n++;
        end
        chk("latency_in_window", 32'(n >= 600 && n <= 640), 32'd1);
        @(posedge clk);
        #1;
        chk("accept_clears_valid", 32'(rx_valid), 32'd0);
      end
    join
    send_bits(16'hFFFF, 2);

    // 9E2: correct parity then flipped parity
    data_bits = 3'b100; parity = 2'b10; stop_bit = 1'b1;
    push(9'h1FF, 1'b0, 1'b0, 1'b0);
    send_frame(9'h1FF, 9, 2, 1'b0, 2, 1'b1);
    send_bits(16'hFFFF, 2);
    push(9'h1FF, 1'b1, 1'b0, 1'b0);
    send_frame(9'h1FF, 9, 2, 1'b1, 2, 1'b1);
    send_bits(16'hFFFF, 2);

    // 5O1: framing error, long break (one word), then a clean frame
    data_bits = 3'b000; parity = 2'b01; stop_bit = 1'b0;
    push(9'h015, 1'b0, 1'b1, 1'b0);
    send_frame(9'h015, 5, 1, 1'b0, 1, 1'b0);
    send_bits(16'hFFFF, 2);
    push(9'h000, 1'b1, 1'b1, 1'b0);
    rx = 1'b0;
    repeat (24 * BIT) @(posedge clk);
    #1;
    rx = 1'b1;
    send_bits(16'hFFFF, 2);
    push(9'h00A, 1'b0, 1'b0, 1'b0);
    send_frame(9'h00A, 5, 1, 1'b0, 1, 1'b1);
    send_bits(16'hFFFF, 2);
    drain("drain_after_break");

    // glitch: 4 ticks low is a false start
    data_bits = 3'b011; parity = 2'b00; stop_bit = 1'b0;
    rx = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("glitch_start_seen", 32'(rx_idle), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (3 * BIT) @(posedge clk);
    #1;
    chk("glitch_no_word{valid,idle}", 32'({rx_valid, rx_idle}), 32'h1);

    // overrun: two frames, nobody accepting
    rx_ready = 1'b0;
    push(9'h022, 1'b0, 1'b0, 1'b1);
    send_frame(9'h011, 8, 0, 1'b0, 1, 1'b1);
    send_frame(9'h022, 8, 0, 1'b0, 1, 1'b1);
    send_bits(16'hFFFF, 1);
    chk("overrun_state{valid,data,oe}", 32'({rx_valid, rx_data, overrun_err}), 32'h445);
    rx_ready = 1'b1;
    drain("drain_overrun");
    send_bits(16'hFFFF, 1);

    // accept coinciding with completion of the second word
    rx_ready = 1'b0;
    push(9'h011, 1'b0, 1'b0, 1'b0);
    push(9'h022, 1'b0, 1'b0, 1'b0);
    send_frame(9'h011, 8, 0, 1'b0, 1, 1'b1);
    fork
      send_frame(9'h022, 8, 0, 1'b0, 1, 1'b1);
      begin
        wait_idle(1'b0, 100, "simul_frame2_started");
        wait_idle(1'b1, 1000, "simul_frame2_done");
        rx_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_ready = 1'b0;
      end
    join
    chk("simul_state{valid,data,oe}", 32'({rx_valid, rx_data, overrun_err}), 32'h444);
    rx_ready = 1'b1;
    drain("drain_simul");
    send_bits(16'hFFFF, 1);

    // reset mid-frame discards the partial word
    fork
      send_frame(9'h05A, 8, 0, 1'b0, 1, 1'b1);
      begin
        repeat (4 * BIT + BIT / 2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        abort_tx = 1'b1;
        chk("midframe_reset_values", 32'({rx_data, rx_valid, parity_err, frame_err, overrun_err, rx_idle}), 32'h001);
      end
    join
    abort_tx = 1'b0;
    send_bits(16'hFFFF, 2);
    chk("no_word_after_reset{valid,idle}", 32'({rx_valid, rx_idle}), 32'h1);
    push(9'h03C, 1'b0, 1'b0, 1'b0);
    send_frame(9'h03C, 8, 0, 1'b0, 1, 1'b1);
    send_bits(16'hFFFF, 2);

    // config change mid-frame is ignored
    push(9'h096, 1'b0, 1'b0, 1'b0);
    fork
      send_frame(9'h096, 8, 0, 1'b0, 1, 1'b1);
      begin
        repeat (3 * BIT) @(posedge clk);
        #1;
        data_bits = 3'b000;
      end
    join
    data_bits = 3'b011;
    send_bits(16'hFFFF, 2);

    drain("final_drain");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the far end of the team's TX block.
- Accepts the serial line from the pad and oversamples it at 16x baud.
- Deframes start / data / optional parity / stop bits using the same runtime configuration encoding as TX (data_bits, parity, stop_bit).
- Presents each received word with a valid/ready handshake to the RX FIFO or the register interface, plus parity, framing and overrun status.

Parameters:
OVERSAMPLE, 16, baud_tick pulses per bit period (power of two, 8 or 16).
SYNC_STAGES, 2, flip-flop stages in the rx input synchronizer (2 or 3).

Ports:
clk  input  1  system clock; the only clock.
rst  input  1  synchronous, active-high reset.
baud_tick  input  1  one-clk enable pulse at OVERSAMPLE x baud rate.
rx_en  input  1  receiver enable; when low, no new start bit is detected.
rx  input  1  asynchronous serial line; idle high.
data_bits  input  3  000=5, 001=6, 010=7, 011=8, 100=9 data bits; others=8.
parity  input  2  01=odd, 10=even, 00/11=none.
stop_bit  input  1  0=one stop bit, 1=two stop bits.
rx_ready  input  1  consumer accepts rx_data this cycle.
rx_data  output  9  received word, LSB-aligned, unused upper bits zero.
rx_valid  output  1  rx_data holds an unconsumed word.
parity_err  output  1  parity mismatch on the word in rx_data.
frame_err  output  1  a stop bit sampled low for the word in rx_data.
overrun_err  output  1  a word was overwritten before it was accepted.
rx_idle  output  1  FSM in IDLE.

Behaviour:
- Reset values: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun_err=0, rx_idle=1, FSM=IDLE, synchronizer stages=1.
- Synchronization: rx passes through SYNC_STAGES flops to give rx_s. All logic uses rx_s.
- Tick counter: the 4-bit tick counter and all sampling advance only on clk cycles with baud_tick=1.
- Configuration latch: data_bits, parity and stop_bit are latched on the IDLE->START transition and are constant for the rest of the frame. Mid-frame config changes have no effect.
- FSM states and transitions:
  - IDLE: rx_en=1 and rx_s=0 on a tick -> START, tick counter cleared.
  - START: on tick count OVERSAMPLE/2-1, sample rx_s.
    - rx_s=1: false start; return to IDLE with no outputs changed.
    - rx_s=0: counter cleared -> DATA.
  - DATA: sample every OVERSAMPLE ticks (bit centre). Shift bits in LSB first. After the Nth bit (N from the latched data_bits) -> PARITY if parity is enabled, else -> STOP.
  - PARITY: sample one bit.
    - Odd: error when XOR(data, parity bit) != 1.
    - Even: error when XOR(data, parity bit) != 0.
  - STOP: sample one bit, or two when stop_bit=1. frame_err_pending is the OR of (sample==0) over the stop samples. Return to IDLE at the last stop sample centre, which allows resynchronization to a start bit half a bit later.
- Completion: on the clk after the last stop sample:
  - rx_data <= assembled word (zero-extended).
  - parity_err and frame_err <= pending values.
  - rx_valid <= 1.
- Handshake:
  - rx_valid stays high until a cycle with rx_valid & rx_ready. The next cycle it clears rx_valid, parity_err, frame_err and overrun_err.
  - rx_data holds its value while rx_valid=1.
- Overrun: a completion arrives while rx_valid=1 and rx_ready=0. The new word and flags overwrite the old ones, overrun_err <= 1, and rx_valid stays 1.
- Completion and accept in the same cycle: the accept consumes the old word. The new word loads with rx_valid=1 and overrun_err=0.
- Break: rx held low through the stop bit delivers data=0 with frame_err=1. The FSM then waits in IDLE for rx_s=1 before arming start detection again, so a long break yields exactly one word.
- rx_en deasserted mid-frame: the frame completes normally. Only new start detection is gated.
- rst asserted mid-frame: everything returns to reset values on the next clk edge and the partial word is discarded.
- rx_idle = (FSM==IDLE), registered.

Test Plan:
- 8N1, OVERSAMPLE=16, send 0xA5 -> rx_data=0x0A5, rx_valid=1 about 9.5 bit times after the start edge; no error flags; accept with rx_ready=1 -> rx_valid=0 next clk.
- 9 bits, even parity, 2 stop bits, send 0x1FF with parity bit 1 -> rx_data=0x1FF, parity_err=0. Repeat with parity bit 0 -> parity_err=1.
- 5 bits, odd parity, send 0x15 with stop bit forced 0 -> rx_data=0x015, frame_err=1. Then rx held low for 3 frame times -> exactly one word, and the next valid frame 0x0A decodes correctly.
- Glitch: rx low for 4 ticks, then high -> FSM returns to IDLE, rx_valid stays 0.
- Overrun and simultaneity:
  - Two back-to-back 8N1 frames 0x11 then 0x22 with rx_ready=0 -> rx_data=0x22, overrun_err=1.
  - Repeat with rx_ready pulsed in the completion cycle of 0x22 -> rx_data=0x22, overrun_err=0.
- Reset and config latch:
  - rst for one clk during bit 3 of 0x5A -> all outputs at reset values, no word delivered; the next frame 0x3C is received cleanly.
  - data_bits changed from 011 to 000 mid-frame -> the frame is still decoded as 8 bits.
